// File: rtl/uart_fifo_ctl_if.sv
// Bus bundle for uart_fifo_ctl: write/read handshake, thresholds, status and error flags.
// The master side is the client (UART engine or core); the slave side is the FIFO.
interface uart_fifo_ctl_if #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 128
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic             i_wr_en;
  logic [WIDTH-1:0] i_wr_data;
  logic             i_rd_en;
  logic [WIDTH-1:0] o_rd_data;
  logic             o_rd_valid;
  logic [LW-1:0]    o_level;
  logic             o_empty;
  logic             o_full;
  logic [LW-1:0]    i_afull_thresh;
  logic [LW-1:0]    i_aempty_thresh;
  logic             o_almostfull;
  logic             o_almostempty;
  logic             o_overflow;
  logic             o_underflow;
  logic             i_clr_err;
  logic [LW-1:0]    o_watermark;

  modport master (
    output i_wr_en, i_wr_data, i_rd_en, i_afull_thresh, i_aempty_thresh, i_clr_err,
    input  o_rd_data, o_rd_valid, o_level, o_empty, o_full, o_almostfull, o_almostempty,
           o_overflow, o_underflow, o_watermark
  );

  modport slave (
    input  i_wr_en, i_wr_data, i_rd_en, i_afull_thresh, i_aempty_thresh, i_clr_err,
    output o_rd_data, o_rd_valid, o_level, o_empty, o_full, o_almostfull, o_almostempty,
           o_overflow, o_underflow, o_watermark
  );
endinterface

// File: rtl/uart_fifo_ctl.sv
// Guarded synchronous FIFO between the UART engines and the text core.
// Registered read data, occupancy level, runtime almost-full/empty thresholds and sticky
// overflow/underflow flags. A write to a full FIFO is accepted when a read happens alongside.
// Optional peak-level tracking is built when UART_FIFO_WATERMARK_EN is defined; otherwise
// o_watermark is tied to zero.
module uart_fifo_ctl #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 128
) (
  input logic          i_clk,
  input logic          i_rst,
  uart_fifo_ctl_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             empty, full, rd_acc, wr_acc;

  assign empty  = (level_q == '0);
  assign full   = (level_q == LW'(DEPTH));
  assign rd_acc = bus.i_rd_en & ~empty;
  // A read in the same cycle frees a slot, so a write to a full FIFO still goes in.
  assign wr_acc = bus.i_wr_en & (~full | bus.i_rd_en);

  // Next-state for pointers, level, read port and sticky flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // Set events take priority over a clear in the same cycle.
    ovf_d = (ovf_q & ~bus.i_clr_err) | (bus.i_wr_en & ~wr_acc);
    udf_d = (udf_q & ~bus.i_clr_err) | (bus.i_rd_en & empty);
  end

  // Control state register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_acc) mem_q[wr_ptr_q] <= bus.i_wr_data;
  end

`ifdef UART_FIFO_WATERMARK_EN
  logic [LW-1:0] wm_q, wm_d;

  // Peak occupancy; a clear restarts tracking from the present level.
  always_comb begin
    wm_d = wm_q;
    if (bus.i_clr_err)       wm_d = level_q;
    else if (level_d > wm_q) wm_d = level_d;
  end

  // Watermark register.
  always_ff @(posedge i_clk) begin
    if (i_rst) wm_q <= '0;
    else       wm_q <= wm_d;
  end

  assign bus.o_watermark = wm_q;
`else
  assign bus.o_watermark = '0;
`endif

  assign bus.o_rd_data     = rd_data_q;
  assign bus.o_rd_valid    = rd_valid_q;
  assign bus.o_level       = level_q;
  assign bus.o_empty       = empty;
  assign bus.o_full        = full;
  assign bus.o_almostfull  = (level_q >= bus.i_afull_thresh);
  assign bus.o_almostempty = (level_q <= bus.i_aempty_thresh);
  assign bus.o_overflow    = ovf_q;
  assign bus.o_underflow   = udf_q;
endmodule
